// File: rtl/ex_ctrl_stage.sv
// ex_ctrl_stage: registered EX-stage ALU control decode with valid/ready flow control and multi-cycle mul/div busy tracking
module ex_ctrl_stage #(
  parameter int INS_W      = 6,
  parameter int ALUOP_W    = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INS_W-1:0]   in_type,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_signExt,
  output logic [ALUOP_W-1:0] out_ALUOp,
  output logic               out_mux1,
  output logic [1:0]         out_mux2,
  output logic               out_illegal,
  output logic               out_md_start,
  output logic               out_md_signed,
  output logic               out_busy
);
  localparam logic [INS_W-1:0] INS_ADD = INS_W'(0), INS_ADDU = INS_W'(1), INS_SUB = INS_W'(2),
    INS_SUBU = INS_W'(3), INS_AND = INS_W'(4), INS_OR = INS_W'(5), INS_XOR = INS_W'(6),
    INS_NOR = INS_W'(7), INS_SLT = INS_W'(8), INS_SLTU = INS_W'(9);
  localparam logic [INS_W-1:0] INS_SLL = INS_W'(10), INS_SRL = INS_W'(11), INS_SRA = INS_W'(12),
    INS_SLLV = INS_W'(13), INS_SRLV = INS_W'(14), INS_SRAV = INS_W'(15);
  localparam logic [INS_W-1:0] INS_JB_MIN = INS_W'(16), INS_JB_MAX = INS_W'(25),
    INS_LS_MIN = INS_W'(26), INS_LS_MAX = INS_W'(33);
  localparam logic [INS_W-1:0] INS_ADDI = INS_W'(34), INS_ADDIU = INS_W'(35), INS_ANDI = INS_W'(36),
    INS_ORI = INS_W'(37), INS_XORI = INS_W'(38), INS_LUI = INS_W'(39), INS_SLTI = INS_W'(40),
    INS_SLTIU = INS_W'(41);
  localparam logic [INS_W-1:0] INS_MULT = INS_W'(42), INS_MULTU = INS_W'(43), INS_DIV = INS_W'(44),
    INS_DIVU = INS_W'(45);
  localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(0), ALU_ADD = ALUOP_W'(1), ALU_ADDU = ALUOP_W'(2),
    ALU_SUB = ALUOP_W'(3), ALU_SUBU = ALUOP_W'(4), ALU_AND = ALUOP_W'(5), ALU_OR = ALUOP_W'(6),
    ALU_XOR = ALUOP_W'(7), ALU_NOR = ALUOP_W'(8), ALU_SLT = ALUOP_W'(9), ALU_SLTU = ALUOP_W'(10),
    ALU_SLL = ALUOP_W'(11), ALU_SRL = ALUOP_W'(12), ALU_SRA = ALUOP_W'(13), ALU_LUI = ALUOP_W'(14),
    ALU_MULT = ALUOP_W'(15), ALU_DIV = ALUOP_W'(16);
  localparam logic       ALU_INPUT1_RS = 1'b0, ALU_INPUT1_RT = 1'b1;
  localparam logic [1:0] ALU_INPUT2_RT = 2'd0, ALU_INPUT2_IMM = 2'd1, ALU_INPUT2_SHAMT = 2'd2,
    ALU_INPUT2_RSV = 2'd3;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signext_q, mux1_q, illegal_q, md_start_q, md_signed_q;
  logic [ALUOP_W-1:0] aluop_q;
  logic [1:0]         mux2_q;
  logic               is_rc, is_sh, is_jb, is_ls, is_ic, is_md, accept, load;
  logic               d_signext, d_mux1, d_illegal, d_md_signed;
  logic [ALUOP_W-1:0] d_aluop;
  logic [1:0]         d_mux2;

  assign is_rc  = in_type <= INS_SLTU;
  assign is_sh  = in_type >= INS_SLL && in_type <= INS_SRAV;
  assign is_jb  = in_type >= INS_JB_MIN && in_type <= INS_JB_MAX;
  assign is_ls  = in_type >= INS_LS_MIN && in_type <= INS_LS_MAX;
  assign is_ic  = in_type >= INS_ADDI && in_type <= INS_SLTIU;
  assign is_md  = in_type >= INS_MULT && in_type <= INS_DIVU;
  assign in_ready = state_q == S_EMPTY || (state_q == S_FULL && out_ready);
  assign accept = in_valid && in_ready;
  assign load   = accept && !flush;

  // Decode the incoming type; ALUOp by opcode, operand selects by type class
  always_comb begin
    d_aluop = ALU_NOP;
    case (in_type)
      INS_ADD, INS_ADDI:    d_aluop = ALU_ADD;
      INS_ADDU, INS_ADDIU:  d_aluop = ALU_ADDU;
      INS_SUB:              d_aluop = ALU_SUB;
      INS_SUBU:             d_aluop = ALU_SUBU;
      INS_AND, INS_ANDI:    d_aluop = ALU_AND;
      INS_OR, INS_ORI:      d_aluop = ALU_OR;
      INS_XOR, INS_XORI:    d_aluop = ALU_XOR;
      INS_NOR:              d_aluop = ALU_NOR;
      INS_SLT, INS_SLTI:    d_aluop = ALU_SLT;
      INS_SLTU, INS_SLTIU:  d_aluop = ALU_SLTU;
      INS_SLL, INS_SLLV:    d_aluop = ALU_SLL;
      INS_SRL, INS_SRLV:    d_aluop = ALU_SRL;
      INS_SRA, INS_SRAV:    d_aluop = ALU_SRA;
      INS_LUI:              d_aluop = ALU_LUI;
      INS_MULT, INS_MULTU:  d_aluop = ALU_MULT;
      INS_DIV, INS_DIVU:    d_aluop = ALU_DIV;
      default:              d_aluop = is_ls ? ALU_ADD : ALU_NOP;
    endcase
    d_mux1 = is_sh ? ALU_INPUT1_RT : ALU_INPUT1_RS;
    d_mux2 = (is_ls || is_ic) ? ALU_INPUT2_IMM :
             is_sh ? (in_type >= INS_SLLV ? ALU_INPUT2_RSV : ALU_INPUT2_SHAMT) : ALU_INPUT2_RT;
    d_signext = is_ls || in_type == INS_ADDI || in_type == INS_SLTI;
    d_illegal = !(is_rc || is_sh || is_jb || is_ls || is_ic || is_md);
    d_md_signed = in_type == INS_MULT || in_type == INS_DIV;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush wins, accepts load, busy counts down to FULL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end else if (state_q == S_BUSY) begin
      state_d = cnt_q == '0 ? S_FULL : S_BUSY;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
    end else if (accept) begin
      state_d = is_md ? S_BUSY : S_FULL;
      cnt_d   = is_md ? CNT_W'(MULDIV_LAT - 1) : cnt_q;
    end else if (state_q == S_FULL && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Decode output register, loaded only on an unflushed accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signext_q   <= 1'b0;
      aluop_q     <= '0;
      mux1_q      <= 1'b0;
      mux2_q      <= '0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_signed_q <= 1'b0;
    end else begin
      md_start_q <= load && is_md;
      illegal_q  <= flush ? 1'b0 : load ? d_illegal : illegal_q;
      if (load) begin
        signext_q   <= d_signext;
        aluop_q     <= d_aluop;
        mux1_q      <= d_mux1;
        mux2_q      <= d_mux2;
        md_signed_q <= d_md_signed;
      end
    end
  end

  assign out_valid     = state_q == S_FULL;
  assign out_busy      = state_q == S_BUSY;
  assign out_signExt   = signext_q;
  assign out_ALUOp     = aluop_q;
  assign out_mux1      = mux1_q;
  assign out_mux2      = mux2_q;
  assign out_illegal   = illegal_q;
  assign out_md_start  = md_start_q;
  assign out_md_signed = md_signed_q;
endmodule

// File: tb/tb_ex_ctrl_stage.sv
// tb_ex_ctrl_stage: scoreboard bench for ex_ctrl_stage with directed vectors
module tb_ex_ctrl_stage;
  localparam logic [5:0] T_ADD = 6'd0, T_ADDU = 6'd1, T_SLLV = 6'd13, T_LW = 6'd30, T_ORI = 6'd37,
    T_SLTI = 6'd40, T_MULT = 6'd42, T_DIVU = 6'd45, T_BAD = 6'd50;

  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, flush = 1'b0, out_ready = 1'b1;
  logic [5:0] in_type = '0;
  logic       out_valid, out_signExt, out_mux1, out_illegal, out_md_start, out_md_signed, out_busy;
  logic [4:0] out_ALUOp;
  logic [1:0] out_mux2;
  logic [10:0] sb[$];
  int compared = 0, mismatched = 0, beats = 0, run = 0, maxrun = 0;

  ex_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_signExt(out_signExt),
    .out_ALUOp(out_ALUOp), .out_mux1(out_mux1), .out_mux2(out_mux2), .out_illegal(out_illegal),
    .out_md_start(out_md_start), .out_md_signed(out_md_signed), .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic sx, input logic [4:0] op, input logic m1,
                                     input logic [1:0] m2, input logic ill, input logic mds);
    return {sx, op, m1, m2, ill, mds};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] t, input logic [10:0] e, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_type  = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    else if (push) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare each beat the DUT hands downstream
  always @(negedge clk) begin
    if (rst_n) begin
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (out_valid && out_ready) begin
        beats++;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL beat_unexpected: got fields 0x%0h with empty scoreboard",
                   {out_signExt, out_ALUOp, out_mux1, out_mux2, out_illegal, out_md_signed});
        end else
          chk("beat", {out_signExt, out_ALUOp, out_mux1, out_mux2, out_illegal, out_md_signed},
              sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, md_n, first_v, bad_rdy;
    logic [10:0] hold;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outs", {out_valid, out_signExt, out_ALUOp, out_mux1, out_mux2, out_illegal,
                       out_md_start, out_md_signed, out_busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    maxrun = 0;
    beats = 0;
    issue(T_ADD,  mk(1'b0, 5'd1,  1'b0, 2'd0, 1'b0, 1'b0), 1);
    issue(T_SLLV, mk(1'b0, 5'd11, 1'b1, 2'd3, 1'b0, 1'b0), 1);
    issue(T_LW,   mk(1'b1, 5'd1,  1'b0, 2'd1, 1'b0, 1'b0), 1);
    issue(T_ORI,  mk(1'b0, 5'd6,  1'b0, 2'd1, 1'b0, 1'b0), 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stream_beats", 32'(beats), 32'd4);
    chk("stream_run", 32'(maxrun), 32'd4);
    @(posedge clk); #1;
    hold = mk(1'b1, 5'd9, 1'b0, 2'd1, 1'b0, 1'b0);
    issue(T_SLTI, hold, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_type = T_ADDU;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", {out_signExt, out_ALUOp, out_mux1, out_mux2, out_illegal, out_md_signed}, hold);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    issue(T_ADDU, mk(1'b0, 5'd2, 1'b0, 2'd0, 1'b0, 1'b0), 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("addu_next_valid", 32'(out_valid), 32'd1);
    chk("addu_next_op", 32'(out_ALUOp), 32'd2);
    @(posedge clk); #1;
    issue(T_MULT, mk(1'b0, 5'd15, 1'b0, 2'd0, 1'b0, 1'b1), 1);
    in_valid = 1'b0;
    busy_n = 0; md_n = 0; first_v = 0; bad_rdy = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) chk("mult_md_signed", 32'(out_md_signed), 32'd1);
      if (out_busy) busy_n++;
      if (out_md_start) md_n++;
      if (out_busy && in_ready) bad_rdy++;
      if (out_valid && first_v == 0) first_v = k;
    end
    chk("mult_busy_cycles", 32'(busy_n), 32'd4);
    chk("mult_md_start_cycles", 32'(md_n), 32'd1);
    chk("mult_ready_while_busy", 32'(bad_rdy), 32'd0);
    chk("mult_valid_cycle", 32'(first_v), 32'd5);
    @(posedge clk); #1;
    issue(T_DIVU, '0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("divu_busy", 32'(out_busy), 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_state", {out_busy, out_valid, in_ready, out_md_start, out_illegal}, 32'b00100);
    @(posedge clk); #1;
    issue(T_ADD, mk(1'b0, 5'd1, 1'b0, 2'd0, 1'b0, 1'b0), 1);
    issue(T_BAD, mk(1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0), 1);
    issue(T_ORI, mk(1'b0, 5'd6, 1'b0, 2'd1, 1'b0, 1'b0), 1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
